// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, screen and sprite geometry,
// and a saturating score helper used by the game-state logic.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    HIT       = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned CAR_W    = 40;
  localparam int unsigned CAR_H    = 60;
  localparam int unsigned OBS_W    = 50;
  localparam int unsigned OBS_H    = 40;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/collision_monitor_if.sv
// Signal bundle between the game front end (frame tick, start button,
// sprite positions) and the collision monitor, plus its game-state outputs.
interface collision_monitor_if;
  import game_pkg::*;

  logic        iFRAME;
  logic        iSTART;
  logic [9:0]  car_h_pos;
  logic [8:0]  car_v_pos;
  logic [9:0]  obs1_h_pos;
  logic [8:0]  obs1_v_pos;
  logic [9:0]  obs2_h_pos;
  logic [8:0]  obs2_v_pos;

  logic        reset_game;
  logic [1:0]  oLIVES;
  logic [15:0] oSCORE;
  logic        oCOLLIDE;
  logic        oGAME_OVER;
  logic        oCAR_VISIBLE;
  game_state_t dbg_state;

  // Timing contract: inputs are sampled on the rising edge of the pixel
  // clock; every output is a register and changes only on that edge.
  modport master (
    output iFRAME, iSTART, car_h_pos, car_v_pos,
           obs1_h_pos, obs1_v_pos, obs2_h_pos, obs2_v_pos,
    input  reset_game, oLIVES, oSCORE, oCOLLIDE, oGAME_OVER,
           oCAR_VISIBLE, dbg_state
  );

  modport slave (
    input  iFRAME, iSTART, car_h_pos, car_v_pos,
           obs1_h_pos, obs1_v_pos, obs2_h_pos, obs2_v_pos,
    output reset_game, oLIVES, oSCORE, oCOLLIDE, oGAME_OVER,
           oCAR_VISIBLE, dbg_state
  );

endinterface

// File: rtl/collision_monitor_rect_overlap.sv
// Axis-aligned rectangle overlap test. Touching edges do not count; sums
// are done in 11 bits so right/bottom edges past the screen never wrap.
module rect_overlap #(
  parameter int unsigned AW = 40,
  parameter int unsigned AH = 60,
  parameter int unsigned BW = 50,
  parameter int unsigned BH = 40
) (
  input  logic [9:0] a_h,
  input  logic [8:0] a_v,
  input  logic [9:0] b_h,
  input  logic [8:0] b_v,
  output logic       overlap
);

  logic [10:0] a_l, a_t, b_l, b_t;
  logic        x_ovl, y_ovl;

  assign a_l = {1'b0, a_h};
  assign a_t = {2'b00, a_v};
  assign b_l = {1'b0, b_h};
  assign b_t = {2'b00, b_v};

  assign x_ovl = (a_l < b_l + 11'(BW)) && (b_l < a_l + 11'(AW));
  assign y_ovl = (a_t < b_t + 11'(BH)) && (b_t < a_t + 11'(AH));

  assign overlap = x_ovl && y_ovl;

endmodule

// File: rtl/collision_monitor.sv
// Per-frame car/obstacle hit detection and the game-state FSM that tracks
// lives, score, post-hit invulnerability with blinking, and game over.
module collision_monitor #(
  parameter int unsigned CAR_W         = game_pkg::CAR_W,
  parameter int unsigned CAR_H         = game_pkg::CAR_H,
  parameter int unsigned OBS_W         = game_pkg::OBS_W,
  parameter int unsigned OBS_H         = game_pkg::OBS_H,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES  = 4
) (
  input logic                iVGA_CLK,
  input logic                iRST,
  collision_monitor_if.slave bus
);
  import game_pkg::*;

  localparam int unsigned CNT_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);

  game_state_t      state_q;
  logic             reset_game_q;
  logic [1:0]       lives_q;
  logic [15:0]      score_q;
  logic             collide_q;
  logic             game_over_q;
  logic             visible_q;
  logic [CNT_W-1:0] inv_cnt_q;
  logic             start_q;

  logic             start_edge;
  logic             hit1, hit2, hit;
  logic [CNT_W-1:0] inv_cnt_inc;
  logic             blink_toggle;

  rect_overlap #(.AW(CAR_W), .AH(CAR_H), .BW(OBS_W), .BH(OBS_H)) u_ovl1 (
    .a_h(bus.car_h_pos), .a_v(bus.car_v_pos),
    .b_h(bus.obs1_h_pos), .b_v(bus.obs1_v_pos),
    .overlap(hit1)
  );

  rect_overlap #(.AW(CAR_W), .AH(CAR_H), .BW(OBS_W), .BH(OBS_H)) u_ovl2 (
    .a_h(bus.car_h_pos), .a_v(bus.car_v_pos),
    .b_h(bus.obs2_h_pos), .b_v(bus.obs2_v_pos),
    .overlap(hit2)
  );

  assign hit          = hit1 | hit2;
  assign start_edge   = bus.iSTART & ~start_q;
  assign inv_cnt_inc  = inv_cnt_q + 1'b1;
  assign blink_toggle = ((32'(inv_cnt_inc) % BLINK_FRAMES) == 0);

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state_q      <= IDLE;
      reset_game_q <= 1'b1;
      lives_q      <= LIVES_RST;
      score_q      <= '0;
      collide_q    <= 1'b0;
      game_over_q  <= 1'b0;
      visible_q    <= 1'b1;
      inv_cnt_q    <= '0;
      start_q      <= 1'b0;
    end else begin
      start_q <= bus.iSTART;
      case (state_q)
        IDLE: begin
          // reset_game stays high through the first PLAYING cycle too
          reset_game_q <= 1'b1;
          lives_q      <= LIVES_RST;
          score_q      <= '0;
          collide_q    <= 1'b0;
          game_over_q  <= 1'b0;
          visible_q    <= 1'b1;
          inv_cnt_q    <= '0;
          if (start_edge) state_q <= PLAYING;
        end

        PLAYING: begin
          reset_game_q <= 1'b0;
          if (bus.iFRAME) begin
            if (hit && lives_q > 2'd1) begin
              lives_q   <= lives_q - 2'd1;
              state_q   <= HIT;
              collide_q <= 1'b1;
              visible_q <= 1'b0;
              inv_cnt_q <= '0;
            end else if (hit) begin
              lives_q     <= 2'd0;
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
              visible_q   <= 1'b1;
            end else begin
              score_q <= sat_inc16(score_q);
            end
          end
        end

        HIT: begin
          reset_game_q <= 1'b0;
          if (bus.iFRAME) begin
            score_q <= sat_inc16(score_q);
            if (inv_cnt_q == CNT_W'(INVULN_FRAMES - 1)) begin
              state_q   <= PLAYING;
              collide_q <= 1'b0;
              visible_q <= 1'b1;
              inv_cnt_q <= '0;
            end else begin
              inv_cnt_q <= inv_cnt_inc;
              if (blink_toggle) visible_q <= ~visible_q;
            end
          end
        end

        GAME_OVER: begin
          reset_game_q <= 1'b0;
          visible_q    <= 1'b1;
          collide_q    <= 1'b0;
          if (start_edge) begin
            state_q      <= PLAYING;
            reset_game_q <= 1'b1;
            lives_q      <= LIVES_RST;
            score_q      <= '0;
            game_over_q  <= 1'b0;
            inv_cnt_q    <= '0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reset_game   = reset_game_q;
  assign bus.oLIVES       = lives_q;
  assign bus.oSCORE       = score_q;
  assign bus.oCOLLIDE     = collide_q;
  assign bus.oGAME_OVER   = game_over_q;
  assign bus.oCAR_VISIBLE = visible_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor: start handshake, touching edges,
// hits, invulnerability/blink, game over and restart, reset, score saturation.
module tb_collision_monitor;
  import game_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  collision_monitor_if bus();

  collision_monitor dut (
    .iVGA_CLK(clk),
    .iRST    (rst),
    .bus     (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_pos(input int ch, input int cv, input int o1h, input int o1v,
                         input int o2h, input int o2v);
    bus.car_h_pos  = 10'(ch);
    bus.car_v_pos  = 9'(cv);
    bus.obs1_h_pos = 10'(o1h);
    bus.obs1_v_pos = 9'(o1v);
    bus.obs2_h_pos = 10'(o2h);
    bus.obs2_v_pos = 9'(o2v);
  endtask

  task automatic frame();
    bus.iFRAME = 1'b1;
    tick();
    bus.iFRAME = 1'b0;
  endtask

  task automatic start_pulse();
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.iFRAME = 1'b0;
    bus.iSTART = 1'b0;
    set_pos(120, 400, 400, 100, 500, 50);
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    check("rst_reset_game", 32'(bus.reset_game), 32'd1);
    check("rst_lives", 32'(bus.oLIVES), 32'd3);
    check("rst_score", 32'(bus.oSCORE), 32'd0);
    check("rst_collide", 32'(bus.oCOLLIDE), 32'd0);
    check("rst_game_over", 32'(bus.oGAME_OVER), 32'd0);
    check("rst_visible", 32'(bus.oCAR_VISIBLE), 32'd1);

    start_pulse();
    check("start_state", 32'(bus.dbg_state), 32'(PLAYING));
    check("start_rg_hi", 32'(bus.reset_game), 32'd1);
    tick();
    check("start_rg_lo", 32'(bus.reset_game), 32'd0);
    check("start_lives", 32'(bus.oLIVES), 32'd3);
    check("start_score", 32'(bus.oSCORE), 32'd0);

    // obstacle bottom row 399 touches car top row 400
    set_pos(120, 400, 120, 360, 500, 50);
    frame();
    check("touch_v_score", 32'(bus.oSCORE), 32'd1);
    check("touch_v_lives", 32'(bus.oLIVES), 32'd3);
    // obstacle left column 160 touches car right edge
    set_pos(120, 400, 160, 400, 500, 50);
    frame();
    check("touch_h_score", 32'(bus.oSCORE), 32'd2);
    check("touch_h_state", 32'(bus.dbg_state), 32'(PLAYING));

    // first hit: obs1 only
    set_pos(120, 400, 120, 380, 500, 50);
    frame();
    check("hit1_lives", 32'(bus.oLIVES), 32'd2);
    check("hit1_collide", 32'(bus.oCOLLIDE), 32'd1);
    check("hit1_visible", 32'(bus.oCAR_VISIBLE), 32'd0);
    check("hit1_score", 32'(bus.oSCORE), 32'd2);

    // overlap held through invulnerability; visibility toggles every 4 frames
    for (int k = 1; k <= 59; k++) begin
      frame();
      check("inv_visible", 32'(bus.oCAR_VISIBLE), 32'((k / 4) % 2));
    end
    check("inv_lives", 32'(bus.oLIVES), 32'd2);
    check("inv_state", 32'(bus.dbg_state), 32'(HIT));
    frame();
    check("inv_end_state", 32'(bus.dbg_state), 32'(PLAYING));
    check("inv_end_visible", 32'(bus.oCAR_VISIBLE), 32'd1);
    check("inv_end_collide", 32'(bus.oCOLLIDE), 32'd0);
    check("inv_end_lives", 32'(bus.oLIVES), 32'd2);
    check("inv_end_score", 32'(bus.oSCORE), 32'd62);

    // second hit: both obstacles overlap, one life lost
    set_pos(120, 400, 120, 380, 130, 390);
    frame();
    check("hit2_lives", 32'(bus.oLIVES), 32'd1);
    check("hit2_state", 32'(bus.dbg_state), 32'(HIT));
    for (int k = 1; k <= 60; k++) frame();
    check("hit2_end_state", 32'(bus.dbg_state), 32'(PLAYING));
    check("hit2_end_score", 32'(bus.oSCORE), 32'd122);

    // third hit: game over
    frame();
    check("go_state", 32'(bus.dbg_state), 32'(GAME_OVER));
    check("go_flag", 32'(bus.oGAME_OVER), 32'd1);
    check("go_lives", 32'(bus.oLIVES), 32'd0);
    check("go_visible", 32'(bus.oCAR_VISIBLE), 32'd1);
    check("go_collide", 32'(bus.oCOLLIDE), 32'd0);
    for (int k = 0; k < 3; k++) frame();
    check("go_score_frozen", 32'(bus.oSCORE), 32'd122);
    check("go_rg", 32'(bus.reset_game), 32'd0);

    // restart with coincident frame: start wins, no overlap evaluation
    bus.iSTART = 1'b1;
    bus.iFRAME = 1'b1;
    tick();
    bus.iFRAME = 1'b0;
    bus.iSTART = 1'b0;
    check("restart_state", 32'(bus.dbg_state), 32'(PLAYING));
    check("restart_lives", 32'(bus.oLIVES), 32'd3);
    check("restart_score", 32'(bus.oSCORE), 32'd0);
    check("restart_rg_hi", 32'(bus.reset_game), 32'd1);
    check("restart_go", 32'(bus.oGAME_OVER), 32'd0);
    tick();
    check("restart_rg_lo", 32'(bus.reset_game), 32'd0);
    check("restart_lives2", 32'(bus.oLIVES), 32'd3);

    // start edge together with a frame while PLAYING is ignored
    set_pos(120, 400, 400, 100, 500, 50);
    bus.iSTART = 1'b1;
    bus.iFRAME = 1'b1;
    tick();
    bus.iFRAME = 1'b0;
    bus.iSTART = 1'b0;
    check("play_start_score", 32'(bus.oSCORE), 32'd1);
    check("play_start_rg", 32'(bus.reset_game), 32'd0);
    check("play_start_state", 32'(bus.dbg_state), 32'(PLAYING));

    // reset while in HIT
    set_pos(120, 400, 120, 380, 500, 50);
    frame();
    check("pre_rst_state", 32'(bus.dbg_state), 32'(HIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    check("mid_rst_rg", 32'(bus.reset_game), 32'd1);
    check("mid_rst_lives", 32'(bus.oLIVES), 32'd3);
    check("mid_rst_collide", 32'(bus.oCOLLIDE), 32'd0);
    check("mid_rst_visible", 32'(bus.oCAR_VISIBLE), 32'd1);
    check("mid_rst_score", 32'(bus.oSCORE), 32'd0);

    // score saturation: a frame every cycle
    set_pos(120, 400, 400, 100, 500, 50);
    start_pulse();
    tick();
    check("sat_start_score", 32'(bus.oSCORE), 32'd0);
    bus.iFRAME = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    check("sat_fffe", 32'(bus.oSCORE), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) tick();
    bus.iFRAME = 1'b0;
    check("sat_ffff", 32'(bus.oSCORE), 32'h0000FFFF);
    check("sat_state", 32'(bus.dbg_state), 32'(PLAYING));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
